out_value_checker: RTL and testbench

- Consumer-side companion to the generated FSM test modules. Those modules drive a 32-bit result register (out1) from their state machine; this block watches that result.
- Each time a test case is armed, it latches one expected value. It then waits for the observed output to equal that value and hold it for a set number of cycles, within a timeout.
- It reports pass or fail and keeps saturating tallies, so a bench needs no $monitor-based scoring.
- It sits in the unit-test harness beside the module under test, on that module's clock.

---
 rtl/out_value_checker_pkg.sv | 13 +
 rtl/out_value_checker_sat_counter.sv | 18 +
 rtl/out_value_checker.sv | 137 +++++++++++++
 tb/tb_out_value_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_value_checker_pkg.sv
// Shared types and constants for the out_value_checker block.
// State encoding keeps IDLE at zero so a cleared register is a safe state.
package out_check_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_MATCH = 2'd1,
        STABLE     = 2'd2,
        REPORT     = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int TALLY_W   = 8;
endpackage

// File: rtl/out_value_checker_sat_counter.sv
// Increment-enable tally that sticks at all-ones instead of wrapping.
module sat_counter
    import out_check_pkg::*;
#(
    parameter int W = TALLY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end
endmodule

// File: rtl/out_value_checker.sv
// Watches a module's result output, waits for it to equal a latched expected
// value for STABLE_CYCLES consecutive samples, and reports pass/fail with tallies.
module out_value_checker
    import out_check_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 64,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   obs_value,
    input  logic [WIDTH-1:0]   exp_value,
    input  logic               exp_valid,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [CNT_W-1:0]   latency,
    output logic [TALLY_W-1:0] pass_count,
    output logic [TALLY_W-1:0] fail_count
);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [CNT_W-1:0]    c_q, c_d;
    logic [STAB_W-1:0]   stab_q, stab_d, stab_inc;
    logic [CNT_W-1:0]    lat_d;
    logic                pass_d, fail_d;
    logic                match, pass_now, inc_pass, inc_fail;

    assign busy     = (state_q == WAIT_MATCH) || (state_q == STABLE);
    assign done     = (state_q == REPORT);
    assign match    = (obs_value == exp_q);
    assign stab_inc = stab_q + STAB_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q   <= '0;
            c_q     <= '0;
            stab_q  <= '0;
            latency <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            exp_q   <= exp_d;
            c_q     <= c_d;
            stab_q  <= stab_d;
            latency <= lat_d;
            pass    <= pass_d;
            fail    <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        c_d      = c_q;
        stab_d   = stab_q;
        lat_d    = latency;
        pass_d   = pass;
        fail_d   = fail;
        pass_now = 1'b0;
        inc_pass = 1'b0;
        inc_fail = 1'b0;
        case (state_q)
            IDLE: begin
                if (exp_valid) begin
                    exp_d   = exp_value;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    lat_d   = '0;
                    c_d     = '0;
                    stab_d  = '0;
                    state_d = WAIT_MATCH;
                end
            end
            WAIT_MATCH, STABLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    c_d = c_q + CNT_W'(1);
                    if (!match) begin
                        stab_d  = '0;
                        state_d = WAIT_MATCH;
                    end else if (state_q == WAIT_MATCH) begin
                        stab_d   = STAB_W'(1);
                        lat_d    = c_q;
                        pass_now = (STABLE_CYCLES == 1);
                        state_d  = STABLE;
                    end else begin
                        stab_d   = stab_inc;
                        pass_now = (stab_inc == STAB_W'(STABLE_CYCLES));
                    end
                    // A completing pass on the last sample beats the timeout.
                    if (pass_now) begin
                        pass_d   = 1'b1;
                        inc_pass = 1'b1;
                        state_d  = REPORT;
                    end else if (c_q == CNT_W'(TIMEOUT - 1)) begin
                        fail_d   = 1'b1;
                        lat_d    = '0;
                        inc_fail = 1'b1;
                        state_d  = REPORT;
                    end
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tallies bump on entry to REPORT so they line up with done.
    sat_counter #(.W(TALLY_W)) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_pass),
        .count (pass_count)
    );

    sat_counter #(.W(TALLY_W)) u_fail_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_fail),
        .count (fail_count)
    );
endmodule

// File: tb/tb_out_value_checker.sv
// Scoreboard bench for out_value_checker: each armed check pushes its expected
// verdict, a monitor pops and compares whenever done is seen.
module tb_out_value_checker;
    localparam int SC = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] obs_value;
    logic [31:0] exp_value;
    logic        exp_valid;
    logic        abort;
    logic        busy, done, pass, fail;
    logic [15:0] latency;
    logic [7:0]  pass_count, fail_count;

    typedef struct {
        logic        p;
        logic        f;
        logic [15:0] lat;
        logic [7:0]  pc;
        logic [7:0]  fc;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   arm_cyc = 0;
    int   pc_m = 0;
    int   fc_m = 0;

    out_value_checker #(
        .WIDTH(32), .STABLE_CYCLES(SC), .TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .obs_value  (obs_value),
        .exp_value  (exp_value),
        .exp_valid  (exp_valid),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .latency    (latency),
        .pass_count (pass_count),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: done is observed 1 time unit after the edge that entered REPORT;
    // "due" is the next edge, i.e. arm edge + STABLE_CYCLES+1 for an immediate match.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if (cyc + 1 !== e.due) begin
                    fails++;
                    $display("FAIL done_cycle got %0d want %0d", cyc + 1, e.due);
                end
                tests++;
                if ({pass, fail} !== {e.p, e.f}) begin
                    fails++;
                    $display("FAIL verdict got pass=%b fail=%b want pass=%b fail=%b", pass, fail, e.p, e.f);
                end
                tests++;
                if (latency !== e.lat) begin
                    fails++;
                    $display("FAIL latency got %0d want %0d", latency, e.lat);
                end
                tests++;
                if (pass_count !== e.pc || fail_count !== e.fc) begin
                    fails++;
                    $display("FAIL tallies got %0d/%0d want %0d/%0d", pass_count, fail_count, e.pc, e.fc);
                end
            end
        end
    end

    task automatic arm(input logic [31:0] v);
        exp_value = v;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        arm_cyc   = cyc;
    endtask

    task automatic push(input bit p, input int lat, input int done_at);
        exp_t e;
        if (p) pc_m = (pc_m == 255) ? 255 : pc_m + 1;
        else   fc_m = (fc_m == 255) ? 255 : fc_m + 1;
        e.p   = p;
        e.f   = !p;
        e.lat = 16'(lat);
        e.pc  = 8'(pc_m);
        e.fc  = 8'(fc_m);
        e.due = arm_cyc + done_at;
        sb.push_back(e);
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        ok = (sb.size() == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; obs_value = '0; exp_value = '0; exp_valid = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, pass, fail} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, pass, fail});
        end
        tests++;
        if (latency !== 16'd0 || pass_count !== 8'd0 || fail_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_values got lat=%0d pc=%0d fc=%0d want 0", latency, pass_count, fail_count);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_match();
        bit ok;
        obs_value = 32'd8;
        arm(32'd8);
        push(1'b1, 0, SC + 1);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL match_busy got %b want 1", busy);
        end
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL match_no_done got pending=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_timeout();
        bit ok;
        obs_value = 32'd7;
        arm(32'd8);
        push(1'b0, 0, TO + 1);
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL timeout_no_done got pending=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_glitch();
        bit ok;
        obs_value = 32'd8;
        arm(32'd8);
        push(1'b1, 3, 8);
        @(posedge clk);
        @(posedge clk);
        #1 obs_value = 32'd0;
        @(posedge clk);
        #1 obs_value = 32'd8;
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL glitch_no_done got pending=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_abort();
        bit ok;
        obs_value = 32'd7;
        arm(32'd8);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
            fails++;
            $display("FAIL abort_state got busy=%b pass=%b fail=%b want 0/0/0", busy, pass, fail);
        end
        repeat (TO + 6) @(posedge clk);
        #1;
        tests++;
        if (pass_count !== 8'(pc_m) || fail_count !== 8'(fc_m)) begin
            fails++;
            $display("FAIL abort_tallies got %0d/%0d want %0d/%0d", pass_count, fail_count, pc_m, fc_m);
        end
        obs_value = 32'd8;
        arm(32'd8);
        push(1'b1, 0, SC + 1);
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rearm_no_done got pending=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ignore();
        bit ok;
        obs_value = 32'd8;
        arm(32'd8);
        push(1'b1, 0, SC + 1);
        exp_value = 32'd5;
        exp_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_value = 32'd0;
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL ignore_no_done got pending=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        obs_value = 32'd8;
        for (int i = 0; i < 260; i++) begin
            arm(32'd8);
            push(1'b1, 0, SC + 1);
            wait_drain(ok);
            if (!ok) begin
                tests++; fails++;
                $display("FAIL b2b_no_done got pending=%0d want 0 at iter %0d", sb.size(), i);
                sb.delete();
                break;
            end
        end
        tests++;
        if (pass_count !== 8'd255) begin
            fails++;
            $display("FAIL saturate got %0d want 255", pass_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        obs_value = 32'd8;
        arm(32'd8);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({busy, done, pass, fail} !== 4'b0000 || latency !== 16'd0 ||
            pass_count !== 8'd0 || fail_count !== 8'd0) begin
            fails++;
            $display("FAIL midreset got flags=%b lat=%0d pc=%0d fc=%0d want all 0",
                     {busy, done, pass, fail}, latency, pass_count, fail_count);
        end
        pc_m = 0;
        fc_m = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        arm(32'd8);
        push(1'b1, 0, SC + 1);
        wait_drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL postreset_no_done got pending=%0d want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_timeout();
        test_glitch();
        test_abort();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
